// File: rtl/smc_frame_ctrl_if.sv
// smc_frame_ctrl_if: parameter-beat input and frame-result output bundle for smc_frame_ctrl.
// master drives the beats and reads results; slave is the controller side.
interface smc_frame_ctrl_if #(
    parameter int RES_W = 10
);
    logic             in_valid;
    logic [1:0]       mode;
    logic [2:0]       W;
    logic [2:0]       V_GS;
    logic [2:0]       V_DS;
    logic             busy;
    logic             out_valid;
    logic [RES_W-1:0] out_n;

    modport master (
        output in_valid, mode, W, V_GS, V_DS,
        input  busy, out_valid, out_n
    );

    modport slave (
        input  in_valid, mode, W, V_GS, V_DS,
        output busy, out_valid, out_n
    );
endinterface

// File: rtl/smc_frame_ctrl.sv
// smc_frame_ctrl: serial six-beat Id/gm calculator with running descending sort and weighted frame sum.
// Optional macro SMC_GAP_ABORT_EN: an in_valid gap during LOAD aborts the frame instead of pausing it.
module smc_frame_ctrl #(
    parameter int FRAME_LEN = 6,
    parameter int RES_W     = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    smc_frame_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN1 = 3'd2,
        DRAIN2 = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam logic [2:0]       LAST_CNT = 3'(FRAME_LEN - 1);
    localparam logic [RES_W-1:0] K3       = RES_W'(3'd3);
    localparam logic [RES_W-1:0] K4       = RES_W'(3'd4);
    localparam logic [RES_W-1:0] K5       = RES_W'(3'd5);

    // Kn = 1/3, Vth = 1; 10-bit intermediates cover the largest product (252).
    function automatic logic [RES_W-1:0] calc_result(
        input logic [2:0] w,
        input logic [2:0] vgs,
        input logic [2:0] vds,
        input logic       is_id
    );
        logic [9:0] w_e;
        logic [9:0] vds_e;
        logic [9:0] ov_e;
        logic [9:0] prod;
        w_e   = {7'd0, w};
        vds_e = {7'd0, vds};
        ov_e  = {7'd0, vgs} - 10'd1;
        if (vgs <= 3'd1) begin
            prod = 10'd0;
        end else if (ov_e > vds_e) begin
            prod = is_id ? (w_e * vds_e * ((10'd2 * ov_e) - vds_e)) : (10'd2 * w_e * vds_e);
        end else begin
            prod = is_id ? (w_e * ov_e * ov_e) : (10'd2 * w_e * ov_e);
        end
        return RES_W'(prod / 10'd3);
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [2:0]       cnt_r;
    logic [2:0]       cnt_s;
    logic [1:0]       mode_r;
    logic             accept_s;
    logic             start_s;
    logic             abort_s;
    logic             emit_s;
    logic             busy_s;
    logic             busy_r;
    logic [RES_W-1:0] res_s;
    logic [RES_W-1:0] res_r;
    logic             res_valid_r;
    logic [RES_W-1:0] list_r [FRAME_LEN];
    logic [RES_W-1:0] ins_s  [FRAME_LEN];
    logic [RES_W-1:0] n0_s;
    logic [RES_W-1:0] n1_s;
    logic [RES_W-1:0] n2_s;
    logic [RES_W-1:0] sum_s;
    logic             out_valid_r;
    logic [RES_W-1:0] out_n_r;

    // Frame sequencing: beat acceptance, count, abort on gaps and result emission.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        start_s  = 1'b0;
        abort_s  = 1'b0;
        emit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    start_s  = 1'b1;
                    cnt_s    = 3'd1;
                    state_s  = LOAD;
                end else begin
                    cnt_s    = 3'd0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    cnt_s    = cnt_r + 3'd1;
                    if (cnt_r == LAST_CNT) begin
                        state_s = DRAIN1;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
`ifdef SMC_GAP_ABORT_EN
                    abort_s = 1'b1;
                    cnt_s   = 3'd0;
                    state_s = IDLE;
`else
                    state_s = LOAD;
`endif
                end
            end
            DRAIN1:  state_s = DRAIN2;
            DRAIN2:  state_s = OUT;
            OUT: begin
                emit_s  = 1'b1;
                cnt_s   = 3'd0;
                state_s = IDLE;
            end
            default: begin
                cnt_s   = 3'd0;
                state_s = IDLE;
            end
        endcase
        // OUT sets busy for the out_valid cycle that follows it.
        busy_s = start_s | emit_s | ((state_r != IDLE) & ~abort_s);
    end

    // Datapath: per-beat result, stable shift-down insertion, half selection and weighted sum.
    always_comb begin
        res_s = calc_result(bus.W, bus.V_GS, bus.V_DS, start_s ? bus.mode[0] : mode_r[0]);
        if (list_r[0] >= res_r) begin
            ins_s[0] = list_r[0];
        end else begin
            ins_s[0] = res_r;
        end
        for (int i = 1; i < FRAME_LEN; i++) begin
            if (list_r[i] >= res_r) begin
                ins_s[i] = list_r[i];
            end else if (list_r[i-1] >= res_r) begin
                ins_s[i] = res_r;
            end else begin
                ins_s[i] = list_r[i-1];
            end
        end
        if (mode_r[1]) begin
            n0_s = list_r[0];
            n1_s = list_r[1];
            n2_s = list_r[2];
        end else begin
            n0_s = list_r[3];
            n1_s = list_r[4];
            n2_s = list_r[5];
        end
        if (mode_r[0]) begin
            sum_s = (K3 * n0_s) + (K4 * n1_s) + (K5 * n2_s);
        end else begin
            sum_s = n0_s + n1_s + n2_s;
        end
    end

    // Control state: FSM, beat count, first-beat mode latch and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            mode_r  <= 2'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            if (start_s) begin
                mode_r <= bus.mode;
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Result register feeds the sorter one cycle later; frame start or abort clears the list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r       <= '0;
            res_valid_r <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                list_r[i] <= '0;
            end
        end else begin
            res_r       <= res_s;
            res_valid_r <= accept_s;
            if (start_s || abort_s) begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    list_r[i] <= '0;
                end
            end else if (res_valid_r) begin
                list_r <= ins_s;
            end else begin
                list_r <= list_r;
            end
        end
    end

    // Frame result register; out_n holds between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_n_r     <= '0;
        end else begin
            out_valid_r <= emit_s;
            if (emit_s) begin
                out_n_r <= sum_s;
            end else begin
                out_n_r <= out_n_r;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_n     = out_n_r;
endmodule

// File: tb/tb_smc_frame_ctrl.sv
// tb_smc_frame_ctrl: randomized and directed frames against a queue-based reference model with a
// decoupled scoreboard monitor; build with the same SMC_GAP_ABORT_EN setting as the design.
module tb_smc_frame_ctrl;
    localparam int RES_W = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   vec   = 0;
    int   err   = 0;

    smc_frame_ctrl_if #(.RES_W(RES_W)) bus ();

    smc_frame_ctrl #(.FRAME_LEN(6), .RES_W(RES_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   beats_q[$];
    int   drain_left = 0;
    int   mode_l     = 0;
    bit   busy_exp   = 1'b0;
    int   last_out   = 0;
    bit   mon_en     = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_calc(input int w, input int vgs, input int vds, input bit is_id);
        int ov;
        if (vgs <= 1) return 0;
        ov = vgs - 1;
        if (ov > vds) return is_id ? (w * vds * (2 * ov - vds)) / 3 : (2 * w * vds) / 3;
        return is_id ? (w * ov * ov) / 3 : (2 * w * ov) / 3;
    endfunction

    function automatic int ref_frame(input int vals[$], input int m);
        int s[$];
        int a;
        int b;
        int c;
        s = vals;
        s.rsort();
        if ((m & 2) != 0) begin
            a = s[0]; b = s[1]; c = s[2];
        end else begin
            a = s[3]; b = s[4]; c = s[5];
        end
        if ((m & 1) != 0) return 3 * a + 4 * b + 5 * c;
        return a + b + c;
    endfunction

    // Reference model advanced once per sampled edge; called at the negedge before that edge.
    task automatic model_step(input bit v, input int m, input int w, input int g, input int d);
        exp_t e;
        if (drain_left > 0) begin
            drain_left--;
            busy_exp = 1'b1;
        end else if (v) begin
            if (beats_q.size() == 0) mode_l = m;
            beats_q.push_back(ref_calc(w, g, d, (mode_l & 1) != 0));
            busy_exp = 1'b1;
            if (beats_q.size() == 6) begin
                e.val = ref_frame(beats_q, mode_l);
                e.due = cyc + 4;
                exp_q.push_back(e);
                beats_q.delete();
                drain_left = 3;
            end
        end else begin
`ifdef SMC_GAP_ABORT_EN
            beats_q.delete();
`endif
            busy_exp = (beats_q.size() > 0);
        end
    endtask

    task automatic beat(input bit v, input int m, input int w, input int g, input int d);
        @(negedge clk);
        bus.in_valid = v;
        bus.mode     = 2'(m);
        bus.W        = 3'(w);
        bus.V_GS     = 3'(g);
        bus.V_DS     = 3'(d);
        model_step(v, m, w, g, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 0, 0, 0, 0);
    endtask

    task automatic same_frame(input int m, input int w, input int g, input int d);
        for (int i = 0; i < 6; i++) beat(1'b1, m, w, g, d);
    endtask

    task automatic mixed_frame(input int m);
        int mw[6] = '{3, 7, 1, 2, 6, 5};
        int mg[6] = '{4, 7, 0, 2, 5, 3};
        int md[6] = '{7, 7, 0, 5, 1, 7};
        for (int i = 0; i < 6; i++) beat(1'b1, m, mw[i], mg[i], md[i]);
    endtask

    // Scoreboard monitor: samples 2 time units after each rising edge, pops when a result is due.
    initial begin
        bit ov_exp;
        int n_exp;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                ov_exp = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                n_exp  = last_out;
                if (ov_exp) begin
                    n_exp    = exp_q[0].val;
                    last_out = n_exp;
                    void'(exp_q.pop_front());
                end
                check("out_valid", int'(bus.out_valid), int'(ov_exp));
                check("out_n", int'(bus.out_n), n_exp);
                check("busy", int'(bus.busy), int'(busy_exp));
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.mode     = 2'd0;
        bus.W        = 3'd0;
        bus.V_GS     = 3'd0;
        bus.V_DS     = 3'd0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_n", int'(bus.out_n), 0);
        check("reset_busy", int'(bus.busy), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        same_frame(1, 1, 3, 1);
        idle(6);
        same_frame(3, 7, 7, 7);
        idle(5);
        same_frame(2, 7, 7, 7);
        idle(5);
        mixed_frame(2);
        idle(5);
        mixed_frame(0);
        idle(5);

        // Back-to-back frames, ignored beats during drain, mode wiggling mid-frame.
        for (int i = 0; i < 6; i++) beat(1'b1, (i == 0) ? 1 : 2, 7 - i, 7, i);
        for (int i = 0; i < 3; i++) beat(1'b1, 3, 7, 7, 7);
        for (int i = 0; i < 6; i++) beat(1'b1, (i == 0) ? 2 : 1, i + 1, 6 - i, 3);
        idle(6);

        // Gap after the third beat.
        for (int i = 0; i < 3; i++) beat(1'b1, 1, i + 2, 5, 2);
        idle(1);
        for (int i = 0; i < 3; i++) beat(1'b1, 1, 4, i + 3, 6);
        idle(6);
        mixed_frame(3);
        idle(5);

        // Asynchronous reset during the fourth beat.
        for (int i = 0; i < 3; i++) beat(1'b1, 3, 5, 6, 2);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.W        = 3'd5;
        rst_n        = 1'b0;
        beats_q.delete();
        exp_q.delete();
        drain_left = 0;
        busy_exp   = 1'b0;
        last_out   = 0;
        #1;
        check("rst_mid_out_valid", int'(bus.out_valid), 0);
        check("rst_mid_out_n", int'(bus.out_n), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        model_step(1'b0, 0, 0, 0, 0);
        mixed_frame(1);
        idle(5);

        // Random traffic with gaps, idle stretches and per-beat mode changes.
        for (int i = 0; i < 400; i++) begin
            beat(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        idle(10);
        check("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/smc_frame_ctrl.md
# smc_frame_ctrl

- Sequential controller for the Super MOSFET Calculator (Kn = 1/3, Vth = 1).
- Accepts one transistor parameter set (W, V_GS, V_DS) per cycle, six per frame, through a single time-shared Id/gm calculator.
- Keeps a running descending-sorted list of the six results and emits one weighted sum per frame with a one-cycle valid pulse.
- Replaces the six-lane parallel datapath wherever inputs arrive serially.

## Interface
- FRAME_LEN, 6: parameter sets per frame; fixed at 6 for this release.
- RES_W, 10: width of per-transistor results and of `out_n`.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  high marks a valid parameter beat.
- mode  in  2  mode[0]: 1 = Id, 0 = gm. mode[1]: 1 = largest three, 0 = smallest three. Sampled on the first beat of a frame only.
- W  in  3  channel width, unsigned 0..7.
- V_GS  in  3  gate-source voltage, unsigned 0..7.
- V_DS  in  3  drain-source voltage, unsigned 0..7.
- busy  out  1  high from the first accepted beat until the out_valid cycle, inclusive.
- out_valid  out  1  one-cycle pulse marking `out_n` valid.
- out_n  out  RES_W  frame result; holds its last value otherwise.

## Operation
- **Calculator**, per beat, with ov = V_GS − 1:
  - Cutoff (V_GS ≤ 1): result = 0.
  - Triode (ov > V_DS):
    - Id = W·V_DS·(2·ov − V_DS)/3
    - gm = 2·W·V_DS/3
  - Saturation (otherwise):
    - Id = W·ov²/3
    - gm = 2·W·ov/3
  - Division is integer floor. Intermediates are at least 9 bits. Max Id = 84, max gm = 28.
- **Sorter**: six RES_W-bit registers s0 ≥ s1 ≥ … ≥ s5.
  - Each registered result is inserted in one cycle: shift-down insertion.
  - Equal values are inserted below existing equals.
  - The list is cleared to 0 on frame start.
- **Selection**:
  - mode[1] = 1: (n0, n1, n2) = (s0, s1, s2).
  - mode[1] = 0: (n0, n1, n2) = (s3, s4, s5).
- **Output**:
  - mode[0] = 1: out_n = 3·n0 + 4·n1 + 5·n2.
  - mode[0] = 0: out_n = n0 + n1 + n2.
  - Maximum 1008; no overflow.
- **FSM states**:
  - IDLE: in_valid → LOAD. Latch mode, cnt = 1, clear list.
  - LOAD: each in_valid beat increments cnt; on the 6th beat → DRAIN.
  - DRAIN: 2 cycles. Pipeline empties: result register, then final insertion. → OUT.
  - OUT: 1 cycle. out_n registered, out_valid = 1. → IDLE.
- **Dropped beats**: in_valid during DRAIN or OUT is ignored, and those beats are not counted.
- **Gaps**: an in_valid-low cycle inside LOAD behaves per Configuration.

## Timing
- **Reset values**: out_valid = 0, out_n = 0, busy = 0, FSM = IDLE, cnt = 0, list = 0, latched mode = 0.
- **Reset mid-frame**: takes effect immediately (asynchronous). The partial frame is discarded and no out_valid is produced.
- **Latency**: if the 6th beat is sampled at edge t, out_valid is high during cycle t+3, i.e. after the edges t+1, t+2, t+3.
- **Frame spacing**: a new frame may start in the cycle after out_valid. With gap-free input, the minimum frame period is 9 cycles.
- **Mode stability**: mode changes mid-frame have no effect.

## Configuration
- Macro: `SMC_GAP_ABORT_EN`.
- **Defined**:
  - An in_valid-low cycle while in LOAD aborts the frame and the FSM returns to IDLE.
  - cnt and the list are cleared, busy drops, and no out_valid is produced.
  - The next in_valid starts a fresh frame.
- **Undefined**:
  - Gaps are tolerated. LOAD holds cnt and the list, and the frame resumes on the next beat.
  - DRAIN is entered only after six beats have been accepted.

## Test plan
- Six beats W=1, V_GS=3, V_DS=1, mode=01 → each Id = 1; out_n = 12 at t+3; busy falls after the out_valid cycle.
- Six beats W=7, V_GS=7, V_DS=7:
  - mode=11 → out_n = 1008.
  - mode=10 → out_n = 84.
- Mixed frame (3,4,7), (7,7,7), (1,0,0), (2,2,5), (6,5,1), (5,3,7) in gm mode:
  - Sorted list is 28, 6, 6, 4, 1, 0.
  - mode=10 → 40; mode=00 → 5.
- Two back-to-back frames (second frame starts the cycle after out_valid); mode changed mid-frame → both results match their first-beat mode; the in_valid beats driven during DRAIN are ignored.
- Gap after the 3rd beat, then 3 more beats:
  - Without `SMC_GAP_ABORT_EN` → normal result one cycle later.
  - With it → no out_valid; a following clean frame gives the correct result.
- rst_n pulsed low during the 4th beat → all outputs 0 immediately, no out_valid; the next full frame gives the correct result.
